// File: rtl/buzzer_seq.sv
// Multi-channel buzzer sequencer: per-channel CONT / PERIODIC / BURST pattern engines.
// Optional BUZZER_SEQ_MIX_EN adds a registered, one-cycle-delayed OR of all channels on mix_out.
module buzzer_seq #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int REP_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   enable,
  input  logic                  cfg_wr,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_W-1:0]      cfg_on,
  input  logic [CNT_W-1:0]      cfg_off,
  input  logic [REP_W-1:0]      cfg_repeat,
  output logic [CHANNELS-1:0]   buzzer_out,
  output logic [CHANNELS-1:0]   active,
  output logic [CHANNELS-1:0]   done,
  output logic                  mix_out,
  output logic [2*CHANNELS-1:0] state_dbg
);

  // Configuration interface: cfg_wr is a single-cycle strobe with no ready;
  // it is accepted on every edge it is high and the cfg_* fields are sampled with it.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF      = 2'd0;
  localparam logic [1:0] MODE_CONT     = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;
  localparam logic [1:0] MODE_BURST    = 2'd3;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] on_q, off_q, cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rem_q, rem_d;
    logic             out_q, done_q;
    logic             cfg_hit;

    assign cfg_hit = cfg_wr && (cfg_ch == CH_W'(i));

    // cnt holds remaining cycles minus one, so a phase of length N never needs N itself
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      if (!enable[i] || (mode_q == MODE_OFF) || cfg_hit) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (mode_q == MODE_CONT) begin
              state_d = S_ON;
            end else if ((mode_q == MODE_BURST) && (rep_q == '0)) begin
              state_d = S_DONE;
            end else if ((on_q == '0) && (off_q == '0)) begin
              state_d = S_IDLE;
            end else if (on_q == '0) begin
              if (mode_q == MODE_BURST) begin
                state_d = S_DONE;
              end else begin
                state_d = S_OFF;
                cnt_d   = off_q - 1'b1;
              end
            end else begin
              state_d = S_ON;
              cnt_d   = on_q - 1'b1;
              rem_d   = rep_q;
            end
          end
          S_ON: begin
            if (mode_q != MODE_CONT) begin
              if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
              end else if ((mode_q == MODE_BURST) && (rem_q <= REP_W'(1))) begin
                state_d = S_DONE;
              end else begin
                if (mode_q == MODE_BURST) rem_d = rem_q - 1'b1;
                if (off_q != '0) begin
                  state_d = S_OFF;
                  cnt_d   = off_q - 1'b1;
                end else begin
                  cnt_d = on_q - 1'b1;
                end
              end
            end
          end
          S_OFF: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else if (on_q != '0) begin
              state_d = S_ON;
              cnt_d   = on_q - 1'b1;
            end else begin
              cnt_d = off_q - 1'b1;
            end
          end
          S_DONE: state_d = S_DONE;
          default: state_d = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_IDLE;
        mode_q  <= MODE_OFF;
        on_q    <= '0;
        off_q   <= '0;
        rep_q   <= '0;
        cnt_q   <= '0;
        rem_q   <= '0;
        out_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rem_q   <= rem_d;
        if (cfg_hit) begin
          mode_q <= cfg_mode;
          on_q   <= cfg_on;
          off_q  <= cfg_off;
          rep_q  <= cfg_repeat;
        end
        out_q  <= (state_d == S_ON);
        done_q <= (state_d == S_DONE) && (state_q != S_DONE);
      end
    end

    assign buzzer_out[i]       = out_q;
    assign active[i]           = (state_q == S_ON) || (state_q == S_OFF);
    assign done[i]             = done_q;
    assign state_dbg[2*i +: 2] = state_q;
  end

`ifdef BUZZER_SEQ_MIX_EN
  logic mix_q;

  always_ff @(posedge clk) begin
    if (reset) mix_q <= 1'b0;
    else       mix_q <= |buzzer_out;
  end

  assign mix_out = mix_q;
`else
  assign mix_out = 1'b0;
`endif

endmodule

// File: tb/tb_buzzer_seq.sv
// Directed bench for buzzer_seq: per-cycle expected {buzzer_out, active, done} queued and popped.
module tb_buzzer_seq;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 32;
  localparam int REP_W    = 8;

  localparam logic [1:0] M_OFF = 2'd0, M_CONT = 2'd1, M_PER = 2'd2, M_BURST = 2'd3;
  localparam logic [2:0] E_ON = 3'b110, E_OFF = 3'b010, E_DONE = 3'b001, E_IDLE = 3'b000;
`ifdef BUZZER_SEQ_MIX_EN
  localparam logic MIX_ON = 1'b1;
`else
  localparam logic MIX_ON = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CHANNELS-1:0]   enable;
  logic                  cfg_wr;
  logic [1:0]            cfg_ch;
  logic [1:0]            cfg_mode;
  logic [CNT_W-1:0]      cfg_on, cfg_off;
  logic [REP_W-1:0]      cfg_repeat;
  logic [CHANNELS-1:0]   buzzer_out, active, done;
  logic                  mix_out;
  logic [2*CHANNELS-1:0] state_dbg;

  logic [2:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  buzzer_seq #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_repeat(cfg_repeat),
    .buzzer_out(buzzer_out), .active(active), .done(done), .mix_out(mix_out),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [2:0] pat, input int n);
    repeat (n) exp_q.push_back(pat);
  endtask

  task automatic run_check(input string tag, input int ch, input int n);
    logic [2:0] e;
    for (int k = 0; k < n; k++) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("%s ch%0d cyc%0d", tag, ch, k),
            {29'd0, buzzer_out[ch], active[ch], done[ch]}, {29'd0, e});
    end
  endtask

  task automatic cfg(input int ch, input logic [1:0] m, input logic [31:0] on,
                     input logic [31:0] off, input logic [7:0] rep);
    cfg_ch     = 2'(ch);
    cfg_mode   = m;
    cfg_on     = on;
    cfg_off    = off;
    cfg_repeat = rep;
    cfg_wr     = 1'b1;
    tick();
    cfg_wr     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_mode = M_OFF;
    cfg_on = '0; cfg_off = '0; cfg_repeat = '0;
    repeat (3) tick();
    check("reset buzzer_out", 32'(buzzer_out), 32'd0);
    check("reset active", 32'(active), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset mix_out", 32'(mix_out), 32'd0);
    check("reset state_dbg", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    tick();

    // ch0 PERIODIC on=3 off=2
    cfg(0, M_PER, 3, 2, 0);
    enable[0] = 1'b1;
    for (int p = 0; p < 2; p++) begin push(E_ON, 3); push(E_OFF, 2); end
    run_check("periodic", 0, 10);
    enable[0] = 1'b0;
    push(E_IDLE, 1);
    run_check("periodic_stop", 0, 1);

    // ch1 BURST on=2 off=1 repeat=3
    cfg(1, M_BURST, 2, 1, 3);
    enable[1] = 1'b1;
    push(E_ON, 2); push(E_OFF, 1); push(E_ON, 2); push(E_OFF, 1); push(E_ON, 2);
    push(E_DONE, 1); push(E_IDLE, 3);
    run_check("burst", 1, 12);
    enable[1] = 1'b0;
    push(E_IDLE, 1);
    run_check("burst_stop", 1, 1);

    // ch2 boundary cases
    cfg(2, M_BURST, 2, 1, 0);
    enable[2] = 1'b1;
    push(E_DONE, 1); push(E_IDLE, 2);
    run_check("burst_rep0", 2, 3);
    enable[2] = 1'b0;
    cfg(2, M_BURST, 0, 1, 2);
    enable[2] = 1'b1;
    push(E_DONE, 1); push(E_IDLE, 2);
    run_check("burst_on0", 2, 3);
    enable[2] = 1'b0;
    cfg(2, M_PER, 0, 0, 0);
    enable[2] = 1'b1;
    push(E_IDLE, 4);
    run_check("periodic_00", 2, 4);
    check("periodic_00 state", 32'(state_dbg[5:4]), 32'd0);
    enable[2] = 1'b0;
    cfg(2, M_PER, 2, 0, 0);
    enable[2] = 1'b1;
    push(E_ON, 6);
    run_check("periodic_off0", 2, 6);
    enable[2] = 1'b0;
    cfg(2, M_PER, 0, 3, 0);
    enable[2] = 1'b1;
    push(E_OFF, 5);
    run_check("periodic_on0", 2, 5);
    enable[2] = 1'b0;
    cfg(2, M_PER, 32'hFFFF_FFFF, 1, 0);
    enable[2] = 1'b1;
    push(E_ON, 8);
    run_check("periodic_onmax", 2, 8);
    enable[2] = 1'b0;

    // cfg_wr to ch3 while enable[3] falls, ch0 running undisturbed
    cfg(0, M_PER, 3, 2, 0);
    cfg(3, M_CONT, 0, 0, 0);
    enable = 4'b1001;
    for (int p = 0; p < 4; p++) begin push(E_ON, 3); push(E_OFF, 2); end
    run_check("ch0_bg", 0, 7);
    cfg_ch = 2'd3; cfg_mode = M_PER; cfg_on = 1; cfg_off = 1; cfg_repeat = 0;
    cfg_wr = 1'b1;
    enable[3] = 1'b0;
    run_check("ch0_bg", 0, 1);
    cfg_wr = 1'b0;
    check("ch3 active after cfg", 32'(active[3]), 32'd0);
    check("ch3 out after cfg", 32'(buzzer_out[3]), 32'd0);
    check("ch3 state after cfg", 32'(state_dbg[7:6]), 32'd0);
    run_check("ch0_bg", 0, 12);
    enable = 4'b1000;
    push(E_ON, 1); push(E_OFF, 1); push(E_ON, 1); push(E_OFF, 1); push(E_ON, 1);
    run_check("ch3_newcfg", 3, 5);
    enable = '0;
    tick();

    // reset mid-ON on all channels
    cfg(0, M_CONT, 0, 0, 0);
    cfg(1, M_BURST, 4, 1, 2);
    cfg(2, M_PER, 5, 5, 0);
    cfg(3, M_CONT, 0, 0, 0);
    enable = 4'hF;
    tick(); tick();
    check("pre-reset all on", 32'(buzzer_out), 32'hF);
    reset = 1'b1;
    tick();
    check("midrst buzzer_out", 32'(buzzer_out), 32'd0);
    check("midrst active", 32'(active), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst mix_out", 32'(mix_out), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("postrst done cyc%0d", k), 32'(done), 32'd0);
      check($sformatf("postrst out cyc%0d", k), 32'(buzzer_out), 32'd0);
    end

    // mix_out follows ch0 CONT one cycle later
    enable = '0;
    cfg(0, M_CONT, 0, 0, 0);
    enable[0] = 1'b1;
    tick();
    check("mix rise out", 32'(buzzer_out), 32'd1);
    check("mix rise lag", 32'(mix_out), 32'd0);
    tick();
    check("mix rise", 32'(mix_out), 32'(MIX_ON));
    enable[0] = 1'b0;
    tick();
    check("mix fall out", 32'(buzzer_out), 32'd0);
    check("mix fall lag", 32'(mix_out), 32'(MIX_ON));
    tick();
    check("mix fall", 32'(mix_out), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
